// File: rtl/bev_bridge_pkg.sv
// Shared types and constants for the BEV-to-DRAM AXI bridge.
package usertype;

  // Bridge sequencing: one request walks AR->R or AW->W->B, then DONE.
  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    AW,
    W,
    B,
    DONE
  } state_t;

  // Byte address of box record 0 in DRAM.
  localparam logic [16:0] DRAM_BASE = 17'h10000;

  // Each box record is 8 bytes; 255*8 plus the base still fits in 17 bits.
  function automatic logic [16:0] box_addr(input logic [16:0] base, input logic [7:0] box);
    return base + {6'b000000, box, 3'b000};
  endfunction

endpackage

// File: rtl/bev_bridge_if.sv
// BEV request/completion signals plus the five AXI channels toward DRAM.
interface INF;
  logic        C_in_valid;
  logic        C_r_wb;
  logic [7:0]  C_addr;
  logic [63:0] C_data_w;
  logic        C_out_valid;
  logic [63:0] C_data_r;

  logic        AR_VALID;
  logic [16:0] AR_ADDR;
  logic        AR_READY;
  logic        R_VALID;
  logic [63:0] R_DATA;
  logic [1:0]  R_RESP;
  logic        R_READY;

  logic        AW_VALID;
  logic [16:0] AW_ADDR;
  logic        AW_READY;
  logic        W_VALID;
  logic [63:0] W_DATA;
  logic        W_READY;
  logic        B_VALID;
  logic [1:0]  B_RESP;
  logic        B_READY;

  // Bridge side.
  modport bridge_inf (
    input  C_in_valid, C_r_wb, C_addr, C_data_w,
    output C_out_valid, C_data_r,
    output AR_VALID, AR_ADDR, input AR_READY,
    input  R_VALID, R_DATA, R_RESP, output R_READY,
    output AW_VALID, AW_ADDR, input AW_READY,
    output W_VALID, W_DATA, input W_READY,
    input  B_VALID, B_RESP, output B_READY
  );

  // BEV requester and DRAM responder side.
  modport bev_dram (
    output C_in_valid, C_r_wb, C_addr, C_data_w,
    input  C_out_valid, C_data_r,
    input  AR_VALID, AR_ADDR, output AR_READY,
    output R_VALID, R_DATA, R_RESP, input R_READY,
    input  AW_VALID, AW_ADDR, output AW_READY,
    input  W_VALID, W_DATA, output W_READY,
    output B_VALID, B_RESP, input B_READY
  );

endinterface

// File: rtl/bev_bridge.sv
// Converts single-cycle BEV box read/write requests into one AXI transaction
// at a time and returns a one-cycle completion pulse. All outputs registered.
module bev_bridge
  import usertype::*;
#(
  parameter logic [16:0] DRAM_BASE = usertype::DRAM_BASE
) (
  input logic       clk,
  input logic       rst_n,
  INF.bridge_inf    inf
);

  state_t      state;
  logic        r_wb_q;
  logic [7:0]  addr_q;
  logic [63:0] data_q;

  // Response codes carry no meaning here; every transaction completes.
  logic unused_resp;
  assign unused_resp = ^{inf.R_RESP, inf.B_RESP};

  // Request sequencing; each VALID/READY output is held until its handshake edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      r_wb_q          <= 1'b0;
      addr_q          <= '0;
      data_q          <= '0;
      inf.C_out_valid <= 1'b0;
      inf.C_data_r    <= '0;
      inf.AR_VALID    <= 1'b0;
      inf.AR_ADDR     <= '0;
      inf.R_READY     <= 1'b0;
      inf.AW_VALID    <= 1'b0;
      inf.AW_ADDR     <= '0;
      inf.W_VALID     <= 1'b0;
      inf.W_DATA      <= '0;
      inf.B_READY     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inf.C_in_valid) begin
            r_wb_q <= inf.C_r_wb;
            addr_q <= inf.C_addr;
            data_q <= inf.C_data_w;
            if (inf.C_r_wb) begin
              inf.AR_VALID <= 1'b1;
              inf.AR_ADDR  <= box_addr(DRAM_BASE, inf.C_addr);
              state        <= AR;
            end else begin
              inf.AW_VALID <= 1'b1;
              inf.AW_ADDR  <= box_addr(DRAM_BASE, inf.C_addr);
              state        <= AW;
            end
          end
        end
        // AR_VALID is always high in this state, so READY alone marks the handshake.
        AR: begin
          if (inf.AR_READY) begin
            inf.AR_VALID <= 1'b0;
            inf.AR_ADDR  <= '0;
            inf.R_READY  <= 1'b1;
            state        <= R;
          end else begin
            inf.AR_ADDR <= box_addr(DRAM_BASE, addr_q);
          end
        end
        R: begin
          if (inf.R_VALID) begin
            inf.R_READY     <= 1'b0;
            inf.C_data_r    <= r_wb_q ? inf.R_DATA : '0;
            inf.C_out_valid <= 1'b1;
            state           <= DONE;
          end
        end
        AW: begin
          if (inf.AW_READY) begin
            inf.AW_VALID <= 1'b0;
            inf.AW_ADDR  <= '0;
            inf.W_VALID  <= 1'b1;
            inf.W_DATA   <= data_q;
            state        <= W;
          end else begin
            inf.AW_ADDR <= box_addr(DRAM_BASE, addr_q);
          end
        end
        W: begin
          if (inf.W_READY) begin
            inf.W_VALID <= 1'b0;
            inf.W_DATA  <= '0;
            inf.B_READY <= 1'b1;
            state       <= B;
          end
        end
        B: begin
          if (inf.B_VALID) begin
            inf.B_READY     <= 1'b0;
            inf.C_data_r    <= '0;
            inf.C_out_valid <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          inf.C_out_valid <= 1'b0;
          inf.C_data_r    <= '0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bev_bridge.sv
// Bench for bev_bridge: drives BEV requests, emulates a DRAM with random
// handshake delays, and checks against a box-indexed memory model.
module tb_bev_bridge;

  localparam logic [16:0] BASE = 17'h10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  INF inf();

  bev_bridge #(.DRAM_BASE(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .inf   (inf)
  );

  int checks = 0;
  int failures = 0;

  logic [63:0] dram [256];  // contents as written through the DUT's AXI outputs
  logic [63:0] refm [256];  // contents as the request stream says they should be

  function automatic logic [16:0] exp_addr(input logic [7:0] box);
    return 17'(int'(BASE) + 8 * int'(box));
  endfunction

  function automatic int addr_to_box(input logic [16:0] a);
    int off;
    off = int'(a) - int'(BASE);
    if (off < 0 || off >= 2048 || (off % 8) != 0) return -1;
    return off / 8;
  endfunction

  // Runs one request through the DUT while acting as DRAM; reports observations only.
  task automatic run_txn(
    input  bit rd, input logic [7:0] box, input logic [63:0] wd,
    input  int unsigned a_d, input int unsigned r_d, input int unsigned w_d,
    input  logic [1:0] resp, input bit poke_r, input bit rst_w,
    output logic [16:0] addr_o, output logic [63:0] wdat_o, output logic [63:0] rdat_o,
    output int unsigned outs, output int unsigned hold_cyc, output int unsigned unstable,
    output int unsigned proto, output bit rst_zero, output bit tmo);
    bit a_pend, a_passed, d_pend, d_passed, rb_pend, rb_done, out_seen, rst_pend, poked;
    int unsigned d_cyc, wait_cnt, tail;
    logic [16:0] a;
    int bx;
    addr_o = '0; wdat_o = '0; rdat_o = '0; outs = 0; hold_cyc = 0; unstable = 0;
    proto = 0; rst_zero = 0; tmo = 1;
    a_pend = 0; a_passed = 0; d_pend = 0; d_passed = 0; rb_pend = 0; rb_done = 0;
    out_seen = 0; rst_pend = 0; poked = 0; d_cyc = 0; wait_cnt = 0; tail = 0;
    @(negedge clk);
    inf.C_in_valid = 1'b1; inf.C_r_wb = rd; inf.C_addr = box; inf.C_data_w = wd;
    for (int unsigned cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      inf.C_in_valid = 1'b0;
      inf.C_r_wb = 1'($urandom);
      inf.C_addr = 8'($urandom);
      inf.C_data_w = {$urandom, $urandom};
      if (rst_pend) begin
        rst_zero = ({inf.C_out_valid, inf.AR_VALID, inf.R_READY, inf.AW_VALID,
                     inf.W_VALID, inf.B_READY} == 6'b0) && (inf.C_data_r == 64'd0) &&
                   (inf.AR_ADDR == 17'd0) && (inf.AW_ADDR == 17'd0) && (inf.W_DATA == 64'd0);
        rst_n = 1'b1;
        tmo = 0;
        break;
      end
      if (a_pend) begin a_pend = 0; a_passed = 1; inf.AR_READY = 0; inf.AW_READY = 0; end
      if (d_pend) begin d_pend = 0; d_passed = 1; inf.W_READY = 0; end
      if (rb_pend) begin rb_pend = 0; inf.R_VALID = 0; inf.B_VALID = 0; end
      if (out_seen) begin
        tail++;
        if (inf.C_out_valid || inf.AR_VALID || inf.AW_VALID || inf.W_VALID ||
            inf.R_READY || inf.B_READY) proto++;
        if (tail == 3) begin tmo = 0; break; end
      end else if (inf.C_out_valid) begin
        outs++;
        rdat_o = inf.C_data_r;
        out_seen = 1;
      end
      if (inf.AW_VALID && inf.W_VALID) proto++;
      if (rd && (inf.AW_VALID || inf.W_VALID || inf.B_READY)) proto++;
      if (!rd && (inf.AR_VALID || inf.R_READY)) proto++;
      if (inf.AR_VALID || inf.AW_VALID) begin
        a = rd ? inf.AR_ADDR : inf.AW_ADDR;
        if (a_passed) proto++;
        else begin
          hold_cyc++;
          if (hold_cyc == 1) addr_o = a;
          else if (a !== addr_o) unstable++;
          if (hold_cyc > a_d) begin
            inf.AR_READY = rd; inf.AW_READY = !rd; a_pend = 1;
          end
        end
      end
      if (rd && a_passed && !rb_done) begin
        if (wait_cnt >= r_d && !inf.R_VALID) begin
          bx = addr_to_box(addr_o);
          inf.R_VALID = 1'b1;
          inf.R_DATA = (bx >= 0) ? dram[bx] : 64'hBAD0_BAD0_BAD0_BAD0;
          inf.R_RESP = resp;
        end
        wait_cnt++;
        if (inf.R_VALID && inf.R_READY) begin rb_pend = 1; rb_done = 1; end
        if (poke_r && inf.R_READY && !poked) begin
          poked = 1; inf.C_in_valid = 1'b1; inf.C_r_wb = 1'b0;
        end
      end
      if (!rd && inf.W_VALID) begin
        if (!a_passed || d_passed) proto++;
        else begin
          d_cyc++;
          if (d_cyc == 1) wdat_o = inf.W_DATA;
          else if (inf.W_DATA !== wdat_o) unstable++;
          if (rst_w) begin rst_n = 1'b0; rst_pend = 1; end
          else if (d_cyc > w_d) begin
            inf.W_READY = 1'b1; d_pend = 1;
            bx = addr_to_box(addr_o);
            if (bx >= 0) dram[bx] = inf.W_DATA;
          end
        end
      end
      if (!rd && d_passed && !rb_done) begin
        if (wait_cnt >= r_d && !inf.B_VALID) begin inf.B_VALID = 1'b1; inf.B_RESP = resp; end
        wait_cnt++;
        if (inf.B_VALID && inf.B_READY) begin rb_pend = 1; rb_done = 1; end
      end
    end
    inf.C_in_valid = 0; inf.AR_READY = 0; inf.AW_READY = 0; inf.W_READY = 0;
    inf.R_VALID = 0; inf.B_VALID = 0; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      inf.C_in_valid = 1'($urandom); inf.C_r_wb = 1'($urandom);
      inf.C_addr = 8'($urandom); inf.C_data_w = {$urandom, $urandom};
    end
    @(negedge clk);
    checks++;
    if ({inf.C_out_valid, inf.AR_VALID, inf.R_READY, inf.AW_VALID, inf.W_VALID, inf.B_READY} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000000", {inf.C_out_valid, inf.AR_VALID,
               inf.R_READY, inf.AW_VALID, inf.W_VALID, inf.B_READY});
    end
    checks++;
    if ({inf.AR_ADDR, inf.AW_ADDR} !== 34'd0) begin
      failures++;
      $display("FAIL reset_addr: got AR=%h AW=%h expected 0", inf.AR_ADDR, inf.AW_ADDR);
    end
    checks++;
    if ({inf.C_data_r, inf.W_DATA} !== 128'd0) begin
      failures++;
      $display("FAIL reset_data: got C_data_r=%h W_DATA=%h expected 0", inf.C_data_r, inf.W_DATA);
    end
    inf.C_in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_read_basic();
    logic [16:0] ad; logic [63:0] wo, ro; int unsigned outs, hold, unst, proto; bit rz, tmo;
    dram[5] = 64'hDEAD_BEEF_0123_4567; refm[5] = 64'hDEAD_BEEF_0123_4567;
    run_txn(1, 8'h05, 64'd0, 0, 3, 0, 2'b00, 0, 0, ad, wo, ro, outs, hold, unst, proto, rz, tmo);
    checks++;
    if (ad !== 17'h10028) begin failures++; $display("FAIL read_addr: got %h expected 10028", ad); end
    checks++;
    if (hold !== 1) begin failures++; $display("FAIL read_ready_same_cycle: AR_VALID cycles %0d expected 1", hold); end
    checks++;
    if (outs !== 1 || tmo) begin failures++; $display("FAIL read_out_count: got %0d (timeout %0d) expected 1", outs, tmo); end
    checks++;
    if (ro !== 64'hDEAD_BEEF_0123_4567) begin failures++; $display("FAIL read_data: got %h expected deadbeef01234567", ro); end
    checks++;
    if (proto !== 0 || unst !== 0) begin failures++; $display("FAIL read_protocol: got %0d/%0d violations expected 0", proto, unst); end
  endtask

  task automatic test_write_basic();
    logic [16:0] ad; logic [63:0] wo, ro; int unsigned outs, hold, unst, proto; bit rz, tmo;
    run_txn(0, 8'hFF, 64'h1, 2, 1, 1, 2'b00, 0, 0, ad, wo, ro, outs, hold, unst, proto, rz, tmo);
    refm[255] = 64'h1;
    checks++;
    if (ad !== 17'h107F8) begin failures++; $display("FAIL write_addr: got %h expected 107f8", ad); end
    checks++;
    if (wo !== 64'h1) begin failures++; $display("FAIL write_wdata: got %h expected 1", wo); end
    checks++;
    if (outs !== 1 || tmo) begin failures++; $display("FAIL write_out_count: got %0d (timeout %0d) expected 1", outs, tmo); end
    checks++;
    if (ro !== 64'd0) begin failures++; $display("FAIL write_data_r: got %h expected 0", ro); end
    checks++;
    if (proto !== 0 || unst !== 0) begin failures++; $display("FAIL write_protocol: got %0d/%0d violations expected 0", proto, unst); end
    checks++;
    if (dram[255] !== 64'h1) begin failures++; $display("FAIL write_dram: got %h expected 1", dram[255]); end
  endtask

  task automatic test_ar_delay();
    logic [16:0] ad; logic [63:0] wo, ro; int unsigned outs, hold, unst, proto; bit rz, tmo;
    logic [7:0] box;
    box = 8'($urandom);
    run_txn(1, box, 64'd0, 10, 2, 0, 2'b01, 0, 0, ad, wo, ro, outs, hold, unst, proto, rz, tmo);
    checks++;
    if (hold !== 11 || unst !== 0) begin
      failures++; $display("FAIL ar_hold: got %0d cycles %0d changes expected 11 cycles 0 changes", hold, unst);
    end
    checks++;
    if (ad !== exp_addr(box)) begin failures++; $display("FAIL ar_delay_addr: got %h expected %h", ad, exp_addr(box)); end
    checks++;
    if (ro !== refm[box] || outs !== 1) begin
      failures++; $display("FAIL ar_delay_data: got %h x%0d expected %h x1", ro, outs, refm[box]);
    end
  endtask

  task automatic test_ignore_during_r();
    logic [16:0] ad; logic [63:0] wo, ro; int unsigned outs, hold, unst, proto; bit rz, tmo;
    logic [7:0] box;
    box = 8'($urandom);
    run_txn(1, box, 64'd0, 1, 5, 0, 2'b00, 1, 0, ad, wo, ro, outs, hold, unst, proto, rz, tmo);
    checks++;
    if (outs !== 1 || tmo) begin failures++; $display("FAIL poke_out_count: got %0d expected 1", outs); end
    checks++;
    if (ro !== refm[box] || proto !== 0) begin
      failures++; $display("FAIL poke_data: got %h proto %0d expected %h proto 0", ro, proto, refm[box]);
    end
  endtask

  task automatic test_reset_in_w();
    logic [16:0] ad; logic [63:0] wo, ro; int unsigned outs, hold, unst, proto; bit rz, tmo;
    logic [7:0] box;
    box = 8'($urandom);
    run_txn(0, box, ~refm[box], 1, 0, 3, 2'b00, 0, 1, ad, wo, ro, outs, hold, unst, proto, rz, tmo);
    checks++;
    if (rz !== 1'b1 || tmo) begin failures++; $display("FAIL rst_w_zero: outputs zero %0d expected 1", rz); end
    checks++;
    if (outs !== 0) begin failures++; $display("FAIL rst_w_no_out: got %0d expected 0", outs); end
    run_txn(1, box, 64'd0, 0, 1, 0, 2'b00, 0, 0, ad, wo, ro, outs, hold, unst, proto, rz, tmo);
    checks++;
    if (ro !== refm[box] || outs !== 1 || ad !== exp_addr(box)) begin
      failures++; $display("FAIL rst_w_followup: got %h@%h x%0d expected %h@%h x1", ro, ad, outs, refm[box], exp_addr(box));
    end
  endtask

  task automatic test_bresp();
    logic [16:0] ad; logic [63:0] wo, ro; int unsigned outs, hold, unst, proto; bit rz, tmo;
    logic [7:0] box; logic [63:0] wd;
    box = 8'($urandom); wd = {$urandom, $urandom};
    run_txn(0, box, wd, 0, 2, 0, 2'b10, 0, 0, ad, wo, ro, outs, hold, unst, proto, rz, tmo);
    refm[box] = wd;
    checks++;
    if (outs !== 1 || tmo || ro !== 64'd0) begin
      failures++; $display("FAIL bresp_out: got x%0d data %h expected x1 data 0", outs, ro);
    end
  endtask

  task automatic test_random();
    logic [16:0] ad; logic [63:0] wo, ro; int unsigned outs, hold, unst, proto; bit rz, tmo;
    logic [7:0] box; logic [63:0] wd, exp_r; bit rd;
    int unsigned bad;
    for (int n = 0; n < 40; n++) begin
      rd = 1'($urandom); box = 8'($urandom_range(0, 15)); wd = {$urandom, $urandom};
      run_txn(rd, box, wd, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              2'($urandom), 0, 0, ad, wo, ro, outs, hold, unst, proto, rz, tmo);
      exp_r = rd ? refm[box] : 64'd0;
      if (!rd) refm[box] = wd;
      checks++;
      if (ad !== exp_addr(box)) begin failures++; $display("FAIL rand_addr[%0d]: got %h expected %h", n, ad, exp_addr(box)); end
      checks++;
      if (ro !== exp_r || outs !== 1 || tmo) begin
        failures++; $display("FAIL rand_result[%0d]: got %h x%0d expected %h x1", n, ro, outs, exp_r);
      end
      checks++;
      if (proto !== 0 || unst !== 0 || (!rd && wo !== wd)) begin
        failures++; $display("FAIL rand_protocol[%0d]: got %0d/%0d violations wdata %h expected 0/0 %h", n, proto, unst, wo, wd);
      end
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (dram[i] !== refm[i]) bad++;
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL dram_contents: got %0d differing boxes expected 0", bad); end
  endtask

  initial begin
    inf.C_in_valid = 0; inf.C_r_wb = 0; inf.C_addr = '0; inf.C_data_w = '0;
    inf.AR_READY = 0; inf.R_VALID = 0; inf.R_DATA = '0; inf.R_RESP = '0;
    inf.AW_READY = 0; inf.W_READY = 0; inf.B_VALID = 0; inf.B_RESP = '0;
    for (int i = 0; i < 256; i++) begin
      dram[i] = {$urandom, $urandom};
      refm[i] = dram[i];
    end
    test_reset();
    test_read_basic();
    test_write_basic();
    test_ar_delay();
    test_ignore_during_r();
    test_reset_in_w();
    test_bresp();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
